// File: rtl/y86_elastic_pipe_reg.sv
// Elastic pipeline register for one Y86-64 instruction bundle, with a valid/ready handshake,
// a two-entry skid buffer, a synchronous bubble flush and an asynchronous reset.
module y86_elastic_pipe_reg #(
  parameter int          WORD_W    = 64,
  parameter logic [2:0]  BUB_STAT  = 3'h1,
  parameter logic [3:0]  BUB_ICODE = 4'h1,
  parameter logic [3:0]  BUB_REG   = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bubble,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_stat,
  input  logic [3:0]        in_icode,
  input  logic [3:0]        in_ifun,
  input  logic [3:0]        in_rA,
  input  logic [3:0]        in_rB,
  input  logic [WORD_W-1:0] in_valC,
  input  logic [WORD_W-1:0] in_valP,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_stat,
  output logic [3:0]        out_icode,
  output logic [3:0]        out_ifun,
  output logic [3:0]        out_rA,
  output logic [3:0]        out_rB,
  output logic [WORD_W-1:0] out_valC,
  output logic [WORD_W-1:0] out_valP,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [2:0]        stat;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [3:0]        ra;
    logic [3:0]        rb;
    logic [WORD_W-1:0] valc;
    logic [WORD_W-1:0] valp;
  } bundle_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // An empty entry always holds this bundle, so downstream decodes a NOP.
  localparam bundle_t BUBBLE = '{
    stat:  BUB_STAT,
    icode: BUB_ICODE,
    ifun:  4'h0,
    ra:    BUB_REG,
    rb:    BUB_REG,
    valc:  {WORD_W{1'b0}},
    valp:  {WORD_W{1'b0}}
  };

  state_t     state_r;
  bundle_t    main_r;
  bundle_t    skid_r;
  logic       out_valid_r;
  logic       in_ready_r;
  logic [1:0] occ_r;
  bundle_t    in_s;
  logic       acc_s;
  logic       pop_s;

  // Pack the upstream fields and decode the handshake strobes.
  always_comb begin
    in_s = '{
      stat:  in_stat,
      icode: in_icode,
      ifun:  in_ifun,
      ra:    in_rA,
      rb:    in_rB,
      valc:  in_valC,
      valp:  in_valP
    };
    acc_s = in_valid & in_ready_r;
    pop_s = out_valid_r & out_ready;
  end

  // Occupancy FSM; handshake outputs are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= EMPTY;
      main_r      <= BUBBLE;
      skid_r      <= BUBBLE;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      occ_r       <= 2'd0;
    end else if (bubble) begin
      state_r     <= EMPTY;
      main_r      <= BUBBLE;
      skid_r      <= BUBBLE;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      occ_r       <= 2'd0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (acc_s) begin
            main_r      <= in_s;
            state_r     <= ONE;
            out_valid_r <= 1'b1;
            in_ready_r  <= 1'b1;
            occ_r       <= 2'd1;
          end
        end
        ONE: begin
          if (acc_s && pop_s) begin
            main_r <= in_s;
          end else if (acc_s) begin
            // Downstream stalled: park the new bundle and close the input.
            skid_r     <= in_s;
            state_r    <= TWO;
            in_ready_r <= 1'b0;
            occ_r      <= 2'd2;
          end else if (pop_s) begin
            main_r      <= BUBBLE;
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
            occ_r       <= 2'd0;
          end
        end
        TWO: begin
          if (pop_s) begin
            main_r     <= skid_r;
            skid_r     <= BUBBLE;
            state_r    <= ONE;
            in_ready_r <= 1'b1;
            occ_r      <= 2'd1;
          end
        end
        default: begin
          state_r     <= EMPTY;
          main_r      <= BUBBLE;
          skid_r      <= BUBBLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          occ_r       <= 2'd0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign occupancy = occ_r;
  assign out_stat  = main_r.stat;
  assign out_icode = main_r.icode;
  assign out_ifun  = main_r.ifun;
  assign out_rA    = main_r.ra;
  assign out_rB    = main_r.rb;
  assign out_valC  = main_r.valc;
  assign out_valP  = main_r.valp;

endmodule

// File: doc/y86_elastic_pipe_reg.md
Name: y86_elastic_pipe_reg

Overview:
- Parametrised successor to the fixed F→D pipeline register.
- Carries one Y86-64 instruction bundle: stat, icode, ifun, rA, rB, valC, valP.
- Adds an elastic valid/ready handshake, a 2-entry skid buffer, a synchronous bubble (flush) input and asynchronous reset.
- Instantiated between any two pipe stages (F/D, D/E, …); upstream stalls come from in_ready, downstream stalls from out_ready.

Parameters:
- WORD_W, 64, width of valC and valP.
- BUB_STAT, 3'h1, stat value injected on reset/bubble/empty (SAOK).
- BUB_ICODE, 4'h1, icode injected on reset/bubble/empty (INOP).
- BUB_REG, 4'hF, rA/rB value injected on reset/bubble/empty (RNONE).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- bubble  in  1  synchronous flush: discard all held bundles
- in_valid  in  1  upstream bundle valid
- in_ready  out  1  buffer can accept; registered, equals skid-empty
- in_stat  in  3  upstream stat
- in_icode  in  4  upstream icode
- in_ifun  in  4  upstream ifun
- in_rA  in  4  upstream rA
- in_rB  in  4  upstream rB
- in_valC  in  WORD_W  upstream constant word
- in_valP  in  WORD_W  upstream next PC
- out_valid  out  1  main entry holds a bundle
- out_ready  in  1  downstream accepts
- out_stat, out_icode, out_ifun, out_rA, out_rB  out  3/4/4/4/4  main entry fields
- out_valC, out_valP  out  WORD_W  main entry words
- occupancy  out  2  held bundles, 0..2

Behaviour:
- Reset:
  - rst=1 asynchronously forces state EMPTY, out_valid=0, in_ready=1, occupancy=0.
  - Output fields take bubble values: stat=BUB_STAT, icode=BUB_ICODE, ifun=0, rA=rB=BUB_REG, valC=valP=0.
  - The skid entry is cleared to the same values.
- Definitions: acc = in_valid & in_ready; pop = out_valid & out_ready; all updates on posedge clk.
- States: EMPTY (occ 0), ONE (occ 1, main valid), TWO (occ 2, main+skid valid, in_ready=0).
- EMPTY:
  - acc → main<=in, ONE.
  - Otherwise hold; outputs show bubble values.
- ONE:
  - acc&pop → main<=in, stay ONE.
  - acc&!pop → skid<=in, TWO.
  - pop&!acc → main<=bubble values, EMPTY.
  - Neither → hold.
- TWO:
  - pop → main<=skid, skid<=bubble values, ONE.
  - Otherwise hold. No accept is possible here because in_ready=0.
- Outputs:
  - out_valid=1 in ONE/TWO; out_* always reflect the main entry.
  - When out_valid=0, out_* equal the bubble values, so downstream decodes a NOP.
- Latency: bundle accepted at edge N is visible on out_* after edge N; throughput one bundle/cycle with out_ready held high.
- in_ready and out_valid are registered; there is no combinational path in→out or out_ready→in_ready.
- Stall: out_valid=1 & out_ready=0 → out_* stable every cycle until pop.
- Bubble:
  - Bubble=1 has priority over acc and pop in the same cycle.
  - Next state EMPTY, both entries set to bubble values, in_ready=1, occupancy=0.
  - An in_valid presented that cycle is dropped, and upstream must not treat it as accepted. Bubble control logic enforces this by also stalling F; the block itself does not signal the drop.
- Reset mid-transfer: pending acc/pop are discarded; held bundles are lost.
- No data-dependent behaviour: fields pass unmodified, with no interpretation of stat/icode.

Test Plan:
- Reset: assert rst mid-cycle with state TWO → immediately out_valid=0, in_ready=1, occupancy=0, out_icode=1, out_stat=1, out_rA=out_rB=F, out_valC=out_valP=0.
- Streaming: out_ready=1, push icode 3,6,7 with valC 0x10,0x20,0x30 on consecutive cycles → each appears one cycle later, in order; occupancy stays 1; in_ready never drops.
- Backpressure: out_ready=0, push A (valP=0x100) then B (valP=0x10A) → occupancy 2, in_ready=0, out_valP holds 0x100; C is offered and not accepted. Raise out_ready → order 0x100, 0x10A, then C after in_ready returns to 1.
- Bubble with TWO held, with in_valid=1 and out_ready=1 in the same cycle → next cycle out_valid=0, occupancy 0, out_icode=1, rA=F; the incoming bundle does not appear later.
- Drain to empty: ONE with pop and no acc → out_valid=0 next cycle, out_* revert to bubble values; a fresh push of icode 8 appears one cycle after acceptance.
- Width: WORD_W=32, push valC=0xDEADBEEF → emerges intact; reset value is 32'h0.
